uart_rx_oversample: RTL and testbench
=====================================

Name: uart_rx_oversample

Overview:
Oversampling UART receiver that pairs with the team's uart_tx as the receiving end of an 8N1 link, with optional parity. It synchronises the asynchronous rx line and validates the start bit at mid-bit. It samples each data, parity and stop bit at its centre using a local oversample tick, then reports the byte with framing, parity and break qualifiers. It replaces the free-running divided-clock receiver wherever error detection is required, and is clocked directly by clk with no derived clocks.

Parameters:
CLK_FREQ, 1_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, line baud rate.
OVERSAMPLE, 8, ticks per bit; even, >= 4.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN=1).

Ports:
clk  input  1  system clock.
rst  input  1  reset, synchronous, active-high.
rx  input  1  asynchronous serial line, idle high.
data_out  output  8  received byte; held until the next valid.
valid  output  1  one-cycle pulse when a frame completes.
frame_err  output  1  stop bit sampled 0; qualified by valid.
parity_err  output  1  parity mismatch; qualified by valid; always 0 when PARITY_EN=0.
break_det  output  1  frame_err with data_out==0x00 and (parity bit==0 or PARITY_EN=0); qualified by valid.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Derived constants: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, minimum 1. BIT_CLKS = DIV*OVERSAMPLE, which is 104 at the defaults.
- Synchroniser: two flops, both reset to 1. rx_s is the second flop. rx_d is rx_s delayed by one cycle, used for edge detection.
- Tick counter:
  - Counts 0..DIV-1; tick is asserted when the count equals DIV-1.
  - Cleared on entry to START and held at 0 in IDLE.
- Sample counter s_cnt: increments on each tick.
- State machine:
  - IDLE: on rx_d==1 and rx_s==0, go to START and clear the tick counter and s_cnt.
  - START: on the tick where s_cnt==OVERSAMPLE/2-1 (mid start bit):
    - if rx_s==0, go to DATA with s_cnt=0 and bit_cnt=0;
    - otherwise this is a glitch: return to IDLE with no outputs.
  - DATA: on the tick where s_cnt==OVERSAMPLE-1, sample rx_s, set s_cnt=0, and shift in LSB first (shreg <= {rx_s, shreg[7:1]}). After the 8th sample, go to PARITY if PARITY_EN, otherwise go to STOP.
  - PARITY: sample at the same point and store p_bit. parity_err = (^shreg ^ p_bit) != PARITY_ODD. Then go to STOP.
  - STOP: sample at the same point.
    - On the next clk: data_out<=shreg, valid=1 for exactly one cycle, frame_err=~stop_sample, parity_err and break_det updated.
    - If stop_sample==1, go to IDLE. The next start edge is accepted from the following cycle; no minimum idle is required.
    - If stop_sample==0, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. No valid is produced during a sustained break.
- Latency: valid rises 1 clk after the mid-stop sample tick, i.e. about 9.5 (or 10.5 with parity) bit times plus 3 clk after the rx falling edge.
- frame_err, parity_err and break_det change only in the valid cycle and hold their value until the next valid.
- Reset values: data_out=0x00, valid=0, frame_err=0, parity_err=0, break_det=0, busy=0, state=IDLE, all counters 0.
- Reset mid-frame aborts immediately with no valid. After reset release, a line that is already low is not taken as a start: a falling edge is required.
- Glitch rejection: a low pulse shorter than about half a bit time returns the block to IDLE silently.

Test Plan:
- Defaults, drive 0xA5 as 8N1 at 104 clk/bit -> exactly one valid pulse; data_out=0xA5; frame_err=0; parity_err=0; busy low after valid.
- rx low for 20 clk then high -> no valid; busy returns to 0 before bit time 1; a following 0x3C frame is received correctly.
- 0x3C with stop bit driven 0, then high after 2 bit times -> valid with data_out=0x3C, frame_err=1, break_det=0; busy stays high until rx returns high.
- PARITY_EN=1, PARITY_ODD=0: 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1, data_out=0x07.
- Back-to-back 0x55 then 0xAA with a single stop bit and no idle gap -> two valid pulses about 1040 clk apart, data 0x55 then 0xAA.
- rx held low for 20 bit times -> exactly one valid with data_out=0x00, frame_err=1, break_det=1. Separately, rst asserted during bit 4 of a frame -> all outputs return to their reset values and no valid is produced.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver with optional parity, mid-bit sampling on a local tick,
// and framing/parity/break qualifiers reported alongside each received byte.
module uart_rx_oversample #(
  parameter int unsigned CLK_FREQ   = 1_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       break_det,
  output logic       busy
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW      = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] s_cnt_q, s_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          p_bit_q, p_bit_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          parity_err_q, parity_err_d;
  logic          break_det_q, break_det_d;

  logic       sync1_q, rx_s_q, rx_d_q;
  logic [2:0] settle_q;
  logic       tick, start_edge;

  // The sync flops come out of reset at 1, so edges are ignored until real line
  // samples have reached rx_d; a line already low at release is never a start.
  assign start_edge = settle_q[2] && rx_d_q && !rx_s_q;
  assign tick       = (state_q != S_IDLE) && (tick_cnt_q == T_LAST);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d      = state_q;
    tick_cnt_d   = (state_q == S_IDLE || tick) ? '0 : tick_cnt_q + 1'b1;
    s_cnt_d      = tick ? s_cnt_q + 1'b1 : s_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    p_bit_d      = p_bit_q;
    data_out_d   = data_out_q;
    valid_d      = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    break_det_d  = break_det_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          s_cnt_d    = '0;
        end
      end
      S_START: begin
        if (tick && s_cnt_q == S_MID) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            s_cnt_d   = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick && s_cnt_q == S_LAST) begin
          s_cnt_d   = '0;
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick && s_cnt_q == S_LAST) begin
          s_cnt_d = '0;
          p_bit_d = rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && s_cnt_q == S_LAST) begin
          s_cnt_d      = '0;
          valid_d      = 1'b1;
          data_out_d   = shreg_q;
          frame_err_d  = !rx_s_q;
          parity_err_d = PARITY_EN && ((^shreg_q ^ p_bit_q) != PARITY_ODD);
          break_det_d  = !rx_s_q && (shreg_q == 8'h00) && (!PARITY_EN || !p_bit_q);
          state_d      = rx_s_q ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      settle_q     <= '0;
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      s_cnt_q      <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      p_bit_q      <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      sync1_q      <= rx;
      rx_s_q       <= sync1_q;
      rx_d_q       <= rx_s_q;
      settle_q     <= {settle_q[1:0], 1'b1};
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      s_cnt_q      <= s_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      p_bit_q      <= p_bit_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      break_det_q  <= break_det_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign break_det  = break_det_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench: directed and randomized frames on a plain 8N1 receiver and an
// even-parity receiver, compared against a frame-level reference model.
module tb_uart_rx_oversample;

  localparam int BIT   = 104;             // 1 MHz / 9600 baud with 8x oversampling
  localparam int LAT   = BIT * 19 / 2 + 3; // start fall to valid, 8N1
  localparam int LAT_P = LAT + BIT;        // one extra bit with parity
  localparam int P_ODD = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic [7:0] data_out, data_out_p;
  logic       valid, frame_err, parity_err, break_det, busy;
  logic       valid_p, frame_err_p, parity_err_p, break_det_p, busy_p;

  uart_rx_oversample dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det), .busy(busy)
  );

  uart_rx_oversample #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .data_out(data_out_p), .valid(valid_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .break_det(break_det_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    logic        fe, pe, bd;
    int unsigned cyc;
  } rec_t;

  rec_t got_q[$], got_p_q[$], exp_q[$], exp_p_q[$];
  int   n_tests = 0, n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (valid === 1'b1) begin
      r.data = data_out; r.fe = frame_err; r.pe = parity_err; r.bd = break_det; r.cyc = cyc;
      got_q.push_back(r);
    end
    if (valid_p === 1'b1) begin
      r.data = data_out_p; r.fe = frame_err_p; r.pe = parity_err_p; r.bd = break_det_p; r.cyc = cyc;
      got_p_q.push_back(r);
    end
  end

  // Frame-level reference: what the receiver must report for one transmitted frame.
  function automatic rec_t model(bit sel, logic [7:0] d, logic pbit, logic stop, int unsigned t0);
    rec_t e;
    e.data = d;
    e.fe   = !stop;
    e.pe   = sel ? ((($countones(d) + int'(pbit)) % 2) != P_ODD) : 1'b0;
    e.bd   = !stop && (d == 8'h00) && (!sel || !pbit);
    e.cyc  = t0;
    return e;
  endfunction

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(bit sel, logic v);
    if (sel) rx_p = v;
    else rx = v;
  endtask

  // Drives start, data LSB first, optional parity and a stop level held for stop_len
  // clocks; the line is left at the stop level for the caller.
  task automatic send_frame(bit sel, logic [7:0] d, logic pbit, logic stop, int stop_len);
    if (sel) exp_p_q.push_back(model(sel, d, pbit, stop, cyc));
    else exp_q.push_back(model(sel, d, pbit, stop, cyc));
    set_line(sel, 1'b0);
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      wait_clks(BIT);
    end
    if (sel) begin
      set_line(sel, pbit);
      wait_clks(BIT);
    end
    set_line(sel, stop);
    wait_clks(stop_len);
  endtask

  task automatic compare(string tag, bit sel);
    rec_t gq[$], eq[$];
    int   lat, n;
    if (sel) begin
      gq = got_p_q; eq = exp_p_q; lat = LAT_P;
      got_p_q.delete(); exp_p_q.delete();
    end else begin
      gq = got_q; eq = exp_q; lat = LAT;
      got_q.delete(); exp_q.delete();
    end
    check($sformatf("%s count", tag), gq.size(), eq.size());
    n = (gq.size() < eq.size()) ? gq.size() : eq.size();
    for (int i = 0; i < n; i++) begin
      int d = int'(gq[i].cyc) - int'(eq[i].cyc);
      check($sformatf("%s[%0d] data", tag, i), gq[i].data, eq[i].data);
      check($sformatf("%s[%0d] frame_err", tag, i), gq[i].fe, eq[i].fe);
      check($sformatf("%s[%0d] parity_err", tag, i), gq[i].pe, eq[i].pe);
      check($sformatf("%s[%0d] break_det", tag, i), gq[i].bd, eq[i].bd);
      check($sformatf("%s[%0d] latency %0d in window", tag, i, d),
            (d >= lat - 3) && (d <= lat + 3), 1);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, " data_out"}, data_out, 8'h00);
    check({tag, " valid"}, valid, 1'b0);
    check({tag, " frame_err"}, frame_err, 1'b0);
    check({tag, " parity_err"}, parity_err, 1'b0);
    check({tag, " break_det"}, break_det, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " busy_p"}, busy_p, 1'b0);
    check({tag, " valid_p"}, valid_p, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       s, p;
    int         t0;

    wait_clks(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(20);

    // Plain 0xA5 frame.
    send_frame(0, 8'hA5, 1'b0, 1'b1, BIT);
    check("a5 busy after valid", busy, 1'b0);
    wait_clks(20);
    check("a5 data held", data_out, 8'hA5);
    compare("a5", 0);

    // Short low glitch is rejected, then a real frame is received.
    rx = 1'b0;
    wait_clks(20);
    check("glitch busy during", busy, 1'b1);
    rx = 1'b1;
    wait_clks(BIT - 22);
    check("glitch busy cleared", busy, 1'b0);
    wait_clks(50);
    send_frame(0, 8'h3C, 1'b0, 1'b1, BIT);
    compare("glitch_then_3c", 0);

    // Stop bit low for two bit times: framing error, receiver waits for line high.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 2 * BIT);
    check("ferr busy while low", busy, 1'b1);
    rx = 1'b1;
    wait_clks(10);
    check("ferr busy after high", busy, 1'b0);
    compare("ferr", 0);

    // Reset during bit 4 (a 0 bit) of 0xE3; line stays low after release.
    d = 8'hE3;
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_clks(BIT);
    end
    rx = d[4];
    wait_clks(BIT / 2);
    rst = 1'b1;
    wait_clks(3);
    check_reset_outputs("midreset");
    rst = 1'b0;
    wait_clks(2 * BIT);
    check("midreset busy low line", busy, 1'b0);
    rx = 1'b1;
    wait_clks(3 * BIT);
    check("midreset busy idle", busy, 1'b0);
    compare("midreset", 0);

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h55, 1'b0, 1'b1, BIT);
    send_frame(0, 8'hAA, 1'b0, 1'b1, BIT);
    wait_clks(20);
    if (got_q.size() == 2)
      check("b2b spacing", got_q[1].cyc - got_q[0].cyc, 10 * BIT);
    compare("b2b", 0);

    // Sustained break.
    exp_q.push_back(model(0, 8'h00, 1'b0, 1'b0, cyc));
    rx = 1'b0;
    wait_clks(20 * BIT);
    check("break busy", busy, 1'b1);
    rx = 1'b1;
    wait_clks(2 * BIT);
    compare("break", 0);

    // Randomized frames, occasional framing errors, random idle gaps.
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 4) != 0);
      send_frame(0, d, 1'b0, s, BIT);
      rx = 1'b1;
      t0 = s ? $urandom_range(0, 30) : $urandom_range(4, 30);
      wait_clks(t0);
    end
    wait_clks(20);
    compare("rand", 0);

    // Even parity receiver: 0x07 has three ones.
    send_frame(1, 8'h07, 1'b1, 1'b1, BIT);
    wait_clks(20);
    send_frame(1, 8'h07, 1'b0, 1'b1, BIT);
    wait_clks(20);
    check("par data_out", data_out_p, 8'h07);
    check("par last parity_err", parity_err_p, 1'b1);
    compare("par", 1);

    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 4) != 0);
      send_frame(1, d, p, s, BIT);
      rx_p = 1'b1;
      wait_clks($urandom_range(4, 30));
    end
    wait_clks(20);
    compare("par_rand", 1);
    check("plain rx idle during parity tests", got_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
